// File: rtl/gf_antilog_unit.sv
// GF(2^8) antilog engine (AES polynomial 0x11B, generator 0x03). It builds its E and L tables
// after reset, then serves exp / mul / inv requests through a two-stage pipeline.
module gf_antilog_unit #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             init_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [TAG_W-1:0] out_tag
);
    // state   | meaning
    // ST_INIT | one E/L table write per cycle, idx 0..255
    // ST_RUN  | tables complete, request pipeline live
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t     state;
    logic [7:0] init_idx;
    logic [7:0] e_reg;

    logic [7:0] e_tab   [256];
    logic [7:0] l_tab_a [256];
    logic [7:0] l_tab_b [256];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // L is skipped at idx 255 so that L[1] keeps 0 instead of wrapping to 255
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            e_tab[init_idx] <= e_reg;
            if (init_idx != 8'hFF) begin
                l_tab_a[e_reg] <= init_idx;
                l_tab_b[e_reg] <= init_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_idx  <= 8'h00;
            e_reg     <= 8'h01;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + 8'd1;
                    e_reg    <= e_reg ^ xtime(e_reg);
                    if (init_idx == 8'hFF) state <= ST_RUN;
                end
                default: init_done <= 1'b1;
            endcase
        end
    end

    logic advance;
    logic in_fire;
    assign advance  = !out_valid || out_ready;
    assign in_ready = init_done && advance;
    assign in_fire  = in_valid && in_ready;

    logic             s1_valid;
    logic [1:0]       s1_op;
    logic [7:0]       s1_a;
    logic [7:0]       s1_la;
    logic [7:0]       s1_lb;
    logic             s1_za;
    logic             s1_zb;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk) begin
        if (advance && in_fire) begin
            s1_op  <= in_op;
            s1_a   <= in_a;
            s1_la  <= l_tab_a[in_a];
            s1_lb  <= l_tab_b[in_b];
            s1_za  <= (in_a == 8'h00);
            s1_zb  <= (in_b == 8'h00);
            s1_tag <= in_tag;
        end
    end

    logic [8:0] s1_sum;
    logic [7:0] s1_idx;
    logic       s1_zero;

    // sum - 255 fits in 8 bits, so the modulo-256 subtract gives the exact reduced index
    always_comb begin
        s1_sum  = {1'b0, s1_la} + {1'b0, s1_lb};
        s1_idx  = 8'h00;
        s1_zero = 1'b1;
        case (s1_op)
            2'b00: begin
                s1_idx  = s1_a;
                s1_zero = 1'b0;
            end
            2'b01: begin
                s1_idx  = (s1_sum >= 9'd255) ? (s1_sum[7:0] - 8'hFF) : s1_sum[7:0];
                s1_zero = s1_za || s1_zb;
            end
            2'b10: begin
                s1_idx  = 8'hFF - s1_la;
                s1_zero = s1_za;
            end
            default: begin
                s1_idx  = 8'h00;
                s1_zero = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_tag   <= '0;
        end else if (advance) begin
            s1_valid  <= in_fire;
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_zero ? 8'h00 : e_tab[s1_idx];
                out_tag  <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_gf_antilog_unit.sv
// Scoreboard bench for gf_antilog_unit: a GF(2^8) reference model predicts each result
// when the request is accepted; a monitor pops and compares as results are consumed.
module tb_gf_antilog_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_done;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_tag;

    gf_antilog_unit #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [3:0] tag;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    bit         chk_lat = 1'b0;
    logic [3:0] tag_ctr = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] model_exp(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < (int'(a) % 255); i++) r = gmul(r, 8'h03);
        return r;
    endfunction

    function automatic logic [7:0] model_inv(input logic [7:0] a);
        logic [7:0] r = 8'h00;
        for (int i = 1; i < 256; i++)
            if (gmul(a, 8'(i)) == 8'h01) r = 8'(i);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data", {24'd0, out_data}, {24'd0, e.data});
                chk("tag", {28'd0, out_tag}, {28'd0, e.tag});
                if (chk_lat) chk("latency", cyc - e.acc, 32'd2);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp);
        int   n   = 0;
        logic acc = 1'b0;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag_ctr;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                e.data = exp;
                e.tag  = tag_ctr;
                e.acc  = cyc;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        tag_ctr  = tag_ctr + 4'd1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    task automatic wait_init();
        int n    = 0;
        int seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (!init_done && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) seen++;
        end
        chk("init_latency", n, 32'd257);
        chk("valid_during_init", seen, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d0;
        logic [3:0] t0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_tag    = 4'h0;
        out_ready = 1'b1;
        #23;
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
        wait_init();
        @(posedge clk); #1;

        send(2'b00, 8'h00, 8'h00, 8'h01);
        send(2'b00, 8'h01, 8'h00, 8'h03);
        send(2'b00, 8'h19, 8'h00, 8'h02);
        send(2'b00, 8'hFF, 8'h00, 8'h01);
        send(2'b00, 8'h80, 8'h00, model_exp(8'h80));
        send(2'b01, 8'h57, 8'h83, 8'hC1);
        send(2'b01, 8'h02, 8'h87, 8'h15);
        send(2'b01, 8'h00, 8'h57, 8'h00);
        send(2'b01, 8'h01, 8'hFF, 8'hFF);
        send(2'b01, 8'h57, 8'h00, 8'h00);
        send(2'b10, 8'h53, 8'h00, 8'hCA);
        send(2'b10, 8'h01, 8'h00, 8'h01);
        send(2'b10, 8'h00, 8'h00, 8'h00);
        send(2'b11, 8'h57, 8'h83, 8'h00);
        drain();

        for (int i = 1; i < 256; i++) begin
            logic [7:0] a;
            logic [7:0] ia;
            a  = 8'(i);
            ia = model_inv(a);
            send(2'b10, a, 8'h00, ia);
            send(2'b01, a, ia, gmul(a, ia));
        end
        drain();

        chk_lat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            send(2'b01, a, b, gmul(a, b));
        end
        drain();
        chk_lat = 1'b0;

        fork
            for (int i = 0; i < 6; i++) begin
                logic [7:0] a;
                logic [7:0] b;
                a = 8'(8'h10 + 8'(i * 7));
                b = 8'(8'hA3 - 8'(i * 11));
                send(2'b01, a, b, gmul(a, b));
            end
            begin
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                @(negedge clk);
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                d0 = out_data;
                t0 = out_tag;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_data", {24'd0, out_data}, {24'd0, d0});
                    chk("stall_tag", {28'd0, out_tag}, {28'd0, t0});
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        send(2'b01, 8'h57, 8'h83, 8'hC1);
        send(2'b10, 8'h53, 8'h00, 8'hCA);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_init_done", {31'd0, init_done}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        wait_init();
        repeat (4) begin @(posedge clk); #1; end
        chk("no_ghost_results", sb.size(), 32'd0);
        send(2'b00, 8'h19, 8'h00, 8'h02);
        send(2'b01, 8'h57, 8'h83, 8'hC1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
